// File: rtl/udp_tx_pkg.sv
// Shared types and helpers for the UDP TX packetizer: read FSM encoding,
// address-width helper for the FIFOs and the packet-size clamp.
package udp_tx_pkg;

    localparam int unsigned LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } rd_state_e;

    // Address bits for a power-of-two FIFO depth (DATA_AW / LEN_AW).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // eff_size = clamp(size, 1, depth)
    function automatic logic [LEN_W-1:0] clamp_size(input logic [LEN_W-1:0] size,
                                                    input int unsigned depth);
        if (size == '0) begin
            return LEN_W'(1);
        end
        if (32'(size) > depth) begin
            return LEN_W'(depth);
        end
        return size;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and a registered 1-cycle read port.
module sync_fifo
    import udp_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             push_c;
    logic             pop_c;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign push_c    = wr_en_i && !full_o;
    assign pop_c     = rd_en_i && !empty_o;
    assign rd_data_o = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Store-and-forward packetizer: cuts a byte stream into packets and releases
// only fully buffered packets to the MAC TX streaming interface.
module udp_tx_packetizer
    import udp_tx_pkg::*;
#(
    parameter int unsigned DATA_DEPTH   = 2048,
    parameter int unsigned LEN_DEPTH    = 8,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  tx_streaming_data,
    output logic        tx_streaming_valid,
    output logic        tx_streaming_last,
    input  logic        tx_streaming_ready,
    input  logic [15:0] packetSize,
    output logic [15:0] drop_count
);

    localparam int unsigned TW          = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_V = TW'(IDLE_TIMEOUT);
    localparam bit TIMEOUT_EN           = (IDLE_TIMEOUT != 0);

    logic             data_full, data_empty, len_full, len_empty;
    logic [7:0]       data_rd;
    logic [LEN_W-1:0] len_rd;

    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] eff_size_q, eff_size_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [15:0]      drop_q, drop_d;

    logic             in_ready_c, accept_c, timeout_c, commit_c, len_push_c;
    logic [LEN_W-1:0] cur_size_c, push_len_c;

    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] rd_rem_q, rd_rem_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic             len_pop_c, data_pop_c, hs_c;

    assign in_ready_c = !reset && !data_full && !len_full;
    assign in_ready   = in_ready_c;
    assign accept_c   = in_valid && in_ready_c;
    assign hs_c       = tx_valid_q && tx_streaming_ready;

    assign tx_streaming_data  = data_rd;
    assign tx_streaming_valid = tx_valid_q;
    assign tx_streaming_last  = tx_last_q;
    assign drop_count         = drop_q;

    sync_fifo #(.WIDTH(8), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (accept_c),
        .wr_data_i (in_data),
        .rd_en_i   (data_pop_c),
        .rd_data_o (data_rd),
        .full_o    (data_full),
        .empty_o   (data_empty)
    );

    sync_fifo #(.WIDTH(LEN_W), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (len_push_c),
        .wr_data_i (push_len_c),
        .rd_en_i   (len_pop_c),
        .rd_data_o (len_rd),
        .full_o    (len_full),
        .empty_o   (len_empty)
    );

    // Write side: byte counting, size latch, idle timeout and commit.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        eff_size_d = eff_size_q;
        timer_d    = timer_q;
        drop_d     = drop_q;
        commit_c   = 1'b0;
        push_len_c = wr_cnt_q;
        cur_size_c = (wr_cnt_q == '0) ? clamp_size(packetSize, DATA_DEPTH) : eff_size_q;
        timeout_c  = TIMEOUT_EN && (wr_cnt_q != '0) && !accept_c
                     && (timer_q == TIMEOUT_V) && !len_full;
        if (accept_c) begin
            eff_size_d = cur_size_c;
            push_len_c = wr_cnt_q + LEN_W'(1);
            commit_c   = (push_len_c == cur_size_c) || in_last;
            wr_cnt_d   = commit_c ? '0 : push_len_c;
            timer_d    = '0;
        end else if (timeout_c) begin
            commit_c = 1'b1;
            wr_cnt_d = '0;
            timer_d  = '0;
        end else if ((wr_cnt_q != '0) && (timer_q != TIMEOUT_V)) begin
            timer_d = timer_q + TW'(1);
        end
        len_push_c = commit_c && (push_len_c != '0);
        if (commit_c && (push_len_c == '0) && (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Read FSM: pop a length, prefetch the first byte, then stream the packet.
    always_comb begin
        state_d    = state_q;
        rd_rem_d   = rd_rem_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        len_pop_c  = 1'b0;
        data_pop_c = 1'b0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
                if (!len_empty) begin
                    len_pop_c = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                rd_rem_d   = len_rd;
                data_pop_c = !data_empty;
                tx_valid_d = 1'b1;
                tx_last_d  = (len_rd == LEN_W'(1));
                state_d    = SEND;
            end
            SEND: begin
                if (hs_c) begin
                    if (rd_rem_q == LEN_W'(1)) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        if (!len_empty) begin
                            len_pop_c = 1'b1;
                            state_d   = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_rem_d   = rd_rem_q - LEN_W'(1);
                        data_pop_c = !data_empty;
                        tx_last_d  = (rd_rem_q == LEN_W'(2));
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q   <= '0;
            eff_size_q <= LEN_W'(1);
            timer_q    <= '0;
            drop_q     <= '0;
            state_q    <= IDLE;
            rd_rem_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            eff_size_q <= eff_size_d;
            timer_q    <= timer_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            rd_rem_q   <= rd_rem_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed bench for udp_tx_packetizer: scripted input bytes, captured output
// handshakes compared against hand-built expected packets.
module tb_udp_tx_packetizer;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [15:0] packet_size;
    logic [15:0] drop_count;

    int          passes;
    int          checks;
    logic [8:0]  got_q[$];
    logic [8:0]  exp_q[$];
    bit          last_acc;
    bit          stall_prev;
    logic        prev_last;
    logic [7:0]  prev_data;
    bit          rand_ready;

    udp_tx_packetizer #(
        .DATA_DEPTH   (64),
        .LEN_DEPTH    (8),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_last            (in_last),
        .in_ready           (in_ready),
        .tx_streaming_data  (tx_data),
        .tx_streaming_valid (tx_valid),
        .tx_streaming_last  (tx_last),
        .tx_streaming_ready (tx_ready),
        .packetSize         (packet_size),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        last_acc = in_valid && in_ready && !reset;
        if (!reset) begin
            if (stall_prev) begin
                check("stall_hold", 32'({tx_valid, tx_last, tx_data}),
                      32'({1'b1, prev_last, prev_data}));
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back({tx_last, tx_data});
            end
            stall_prev = tx_valid && !tx_ready;
            prev_last  = tx_last;
            prev_data  = tx_data;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rand_ready) begin
            tx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            cycle();
            if (last_acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            check("send_timeout", 32'(ok), 32'd1);
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) begin
            cycle();
        end
    endtask

    function automatic void exp_push(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endfunction

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        tx_ready    = 1'b0;
        packet_size = '0;
        passes      = 0;
        checks      = 0;
        stall_prev  = 1'b0;
        prev_last   = 1'b0;
        prev_data   = '0;
        rand_ready  = 1'b0;
        last_acc    = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid",    32'(tx_valid), 32'd0);
        check("rst_last",     32'(tx_last),  32'd0);
        check("rst_data",     32'(tx_data),  32'd0);
        check("rst_drop",     32'(drop_count), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Fixed-size cutting plus idle-timeout close of the tail
        tx_ready    = 1'b1;
        packet_size = 16'd4;
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(i), 1'b0);
        end
        repeat (10) cycle();
        check("t1_tail_held", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 10; i++) begin
            exp_push(8'(i), (i == 3) || (i == 7) || (i == 9));
        end
        wait_out(10, 80);
        compare_q("t1");

        // in_last closes a short packet
        packet_size = 16'd100;
        for (int i = 0; i < 37; i++) begin
            send_byte(8'(8'h80 + i), i == 36);
            exp_push(8'(8'h80 + i), i == 36);
        end
        wait_out(37, 120);
        compare_q("t2");

        // Random backpressure over 50 x 64-byte packets
        packet_size = 16'd64;
        rand_ready  = 1'b1;
        for (int p = 0; p < 50; p++) begin
            for (int i = 0; i < 64; i++) begin
                send_byte(8'(p * 5 + i), 1'b0);
                exp_push(8'(p * 5 + i), i == 63);
            end
        end
        wait_out(3200, 20000);
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        compare_q("t3");

        // Buffer full with the output stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(255 - i), 1'b0);
            exp_push(8'(255 - i), i == 63);
        end
        check("t4_full_in_ready", 32'(in_ready), 32'd0);
        repeat (4) cycle();
        check("t4_stalled_valid", 32'(tx_valid), 32'd1);
        check("t4_stalled_count", 32'(got_q.size()), 32'd0);
        tx_ready = 1'b1;
        wait_out(64, 200);
        repeat (5) cycle();
        check("t4_in_ready_back", 32'(in_ready), 32'd1);
        compare_q("t4");

        // Size change mid-packet, then zero size
        packet_size = 16'd8;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h10 + i), 1'b0);
        end
        packet_size = 16'd3;
        for (int i = 3; i < 11; i++) begin
            send_byte(8'(8'h10 + i), 1'b0);
        end
        packet_size = 16'd0;
        send_byte(8'h1b, 1'b0);
        send_byte(8'h1c, 1'b0);
        for (int i = 0; i < 13; i++) begin
            exp_push(8'(8'h10 + i), (i == 7) || (i == 10) || (i == 11) || (i == 12));
        end
        wait_out(13, 100);
        compare_q("t5");

        // Reset in the middle of a 16-byte packet
        packet_size = 16'd16;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h60 + i), 1'b0);
        end
        wait_out(5, 100);
        reset = 1'b1;
        cycle();
        check("t6_valid_after_rst", 32'(tx_valid), 32'd0);
        check("t6_in_ready_in_rst", 32'(in_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_push(8'(8'h60 + i), 1'b0);
        end
        compare_q("t6_pre");
        packet_size = 16'd4;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h70 + i), 1'b0);
            exp_push(8'(8'h70 + i), i == 3);
        end
        wait_out(4, 50);
        repeat (8) cycle();
        compare_q("t6_post");

        check("drop_count_end", 32'(drop_count), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
